// File: rtl/z80_bus_ctrl.sv
`default_nettype none
// =====================================================================
// Module  : z80_bus_ctrl
// Brief   : CPU clock-enable divider, 1-cycle-latency RAM sequencer with
//           wait states, and periodic interrupt request generator.
// Options : define IRQ_MISS_CNT_EN to add the irq_miss counter output.
// Rev     : 1.0
// =====================================================================
module z80_bus_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 4,
    parameter int WAIT_STATES = 0,
    parameter int INT_PERIOD  = 20000,
    parameter int INT_HOLD    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cpu_ce,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              irq,
    input  logic              irq_ack
`ifdef IRQ_MISS_CNT_EN
    ,
    output logic [7:0]        irq_miss
`endif
);

    localparam int c_DIV_W  = $clog2(CLK_DIV);
    localparam int c_PER_W  = $clog2(INT_PERIOD);
    localparam int c_HOLD_W = $clog2(INT_HOLD + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_PER_W-1:0]  c_PER_LAST = c_PER_W'(INT_PERIOD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(INT_HOLD);
    localparam logic [3:0]          c_WS_LAST  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit                  c_HAS_WAIT = (WAIT_STATES > 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DATA  = 2'd3;

    logic [c_DIV_W-1:0]  div_q, div_d;
    logic [1:0]          state_q, state_d;
    logic                wr_q, wr_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic                cpu_wait_q, cpu_wait_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [c_PER_W-1:0]  per_q, per_d;
    logic [c_HOLD_W-1:0] hold_q, hold_d;
    logic                irq_q, irq_d;

    logic                w_ce;
    logic                w_wrap;
    logic [c_HOLD_W-1:0] w_hold_inc;

    // Strobes are gated by reset so an aborted access stops driving at once.
    assign w_ce       = (div_q == c_DIV_LAST) && !reset;
    assign w_wrap     = w_ce && (per_q == c_PER_LAST);
    assign w_hold_inc = hold_q + 1'b1;

    assign cpu_ce    = w_ce;
    assign cpu_wait  = cpu_wait_q && !reset;
    assign mem_we    = (state_q == c_ISSUE) && wr_q && !reset;
    assign cpu_rdata = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign irq       = irq_q;

    always_comb begin
        div_d = (div_q == c_DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        wcnt_d      = wcnt_q;
        cpu_wait_d  = cpu_wait_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            c_IDLE: begin
                if (w_ce && (cpu_rd || cpu_we)) begin
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    wr_d        = cpu_we;
                    cpu_wait_d  = 1'b1;
                    state_d     = c_ISSUE;
                end
            end
            c_ISSUE: begin
                wcnt_d  = '0;
                state_d = c_HAS_WAIT ? c_WAIT : c_DATA;
            end
            c_WAIT: begin
                if (wcnt_q == c_WS_LAST) begin
                    state_d = c_DATA;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            c_DATA: begin
                // RAM output has been stable since the cycle after ISSUE.
                if (!wr_q) begin
                    rdata_d = mem_rdata;
                end
                cpu_wait_d = 1'b0;
                state_d    = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        per_d  = per_q;
        hold_d = hold_q;
        irq_d  = irq_q;
        if (w_ce) begin
            per_d = (per_q == c_PER_LAST) ? '0 : per_q + 1'b1;
        end
        // A fresh request overrides any acknowledge arriving on the same enable.
        if (w_wrap) begin
            irq_d  = 1'b1;
            hold_d = '0;
        end else if (w_ce && irq_q) begin
            hold_d = w_hold_inc;
            if (irq_ack || (w_hold_inc == c_HOLD_MAX)) begin
                irq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            state_q     <= c_IDLE;
            wr_q        <= 1'b0;
            wcnt_q      <= '0;
            cpu_wait_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            per_q       <= '0;
            hold_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            wr_q        <= wr_d;
            wcnt_q      <= wcnt_d;
            cpu_wait_q  <= cpu_wait_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            per_q       <= per_d;
            hold_q      <= hold_d;
            irq_q       <= irq_d;
        end
    end

`ifdef IRQ_MISS_CNT_EN
    logic [7:0] miss_q, miss_d;
    logic       w_expire;

    assign w_expire = w_ce && irq_q && !w_wrap && !irq_ack && (w_hold_inc == c_HOLD_MAX);
    assign irq_miss = miss_q;

    always_comb begin
        miss_d = miss_q;
        if ((w_expire || (w_wrap && irq_q)) && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_ctrl.sv
`default_nettype none
// =====================================================================
// Module  : tb_z80_bus_ctrl
// Brief   : Self-checking bench for z80_bus_ctrl; instance 0 has no wait
//           states, instance 1 has three. Honours IRQ_MISS_CNT_EN.
// Rev     : 1.0
// =====================================================================
module tb_z80_bus_ctrl;

    typedef struct {
        bit          rd;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cpu_ce, cpu_rd, cpu_we, cpu_wait, mem_we, irq, irq_ack;
    logic [15:0] cpu_addr  [2];
    logic [15:0] mem_addr  [2];
    logic [7:0]  cpu_wdata [2];
    logic [7:0]  cpu_rdata [2];
    logic [7:0]  mem_wdata [2];
`ifdef IRQ_MISS_CNT_EN
    logic [7:0]  irq_miss  [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] ram [0:255];
        logic [7:0] rdata_g;

        z80_bus_ctrl #(
            .ADDR_W(16), .DATA_W(8), .CLK_DIV(4),
            .WAIT_STATES((g == 0) ? 0 : 3), .INT_PERIOD(10), .INT_HOLD(3)
        ) u_dut (
            .clk(clk), .reset(reset), .cpu_ce(cpu_ce[g]),
            .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_rd(cpu_rd[g]), .cpu_we(cpu_we[g]),
            .cpu_rdata(cpu_rdata[g]), .cpu_wait(cpu_wait[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_we(mem_we[g]), .mem_rdata(rdata_g),
            .irq(irq[g]), .irq_ack(irq_ack[g])
`ifdef IRQ_MISS_CNT_EN
            , .irq_miss(irq_miss[g])
`endif
        );

        // Synchronous RAM, one clock read latency, preloaded on reset.
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) ram[i] <= (i == 64) ? 8'h3C : 8'h00;
            end else if (mem_we[g]) begin
                ram[mem_addr[g][7:0]] <= mem_wdata[g];
            end
            rdata_g <= ram[mem_addr[g][7:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge preceding a cpu_ce edge.
    task automatic wait_ce(input int d);
        int n = 0;
        while (cpu_ce[d] !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (cpu_ce[d] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ce_timeout: got no cpu_ce within 16 clks, expected one");
        end
    endtask

    task automatic xact(input int d, input vec_t v, input string tag);
        int          wait_len = 0;
        int          we_cnt   = 0;
        int          ws       = (d == 0) ? 0 : 3;
        logic [15:0] cap_addr = '0;
        logic [7:0]  cap_wd   = '0;
        @(negedge clk);
        wait_ce(d);
        cpu_rd[d]    = v.rd;
        cpu_we[d]    = v.we;
        cpu_addr[d]  = v.addr;
        cpu_wdata[d] = v.wdata;
        @(posedge clk);
        #1;
        cpu_rd[d] = 1'b0;
        cpu_we[d] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_we[d] === 1'b1) we_cnt++;
            if (cpu_wait[d] !== 1'b1) break;
            wait_len++;
            if (i == 0) begin
                cap_addr = mem_addr[d];
                cap_wd   = mem_wdata[d];
            end
        end
        check({tag, " wait_len"}, wait_len, 2 + ws);
        check({tag, " mem_we_pulses"}, we_cnt, v.we ? 1 : 0);
        check({tag, " mem_addr"}, cap_addr, v.addr);
        if (v.we) check({tag, " mem_wdata"}, cap_wd, v.wdata);
        check({tag, " cpu_rdata"}, cpu_rdata[d], v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        logic [32:0] exp_irq;
        logic [32:0] ack_on;

        vecs[0] = '{rd: 1'b0, we: 1'b1, addr: 16'h1234, wdata: 8'hA5, exp_rdata: 8'h00};
        vecs[1] = '{rd: 1'b1, we: 1'b0, addr: 16'h0040, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[2] = '{rd: 1'b1, we: 1'b0, addr: 16'h1234, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[3] = '{rd: 1'b1, we: 1'b1, addr: 16'h0010, wdata: 8'h77, exp_rdata: 8'hA5};
        vecs[4] = '{rd: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp_rdata: 8'h77};
        vecs[5] = '{rd: 1'b0, we: 1'b1, addr: 16'h00FF, wdata: 8'h5A, exp_rdata: 8'h77};
        vecs[6] = '{rd: 1'b1, we: 1'b0, addr: 16'h00FF, wdata: 8'h00, exp_rdata: 8'h5A};
        vecs[7] = '{rd: 1'b1, we: 1'b0, addr: 16'h0040, wdata: 8'h00, exp_rdata: 8'h3C};

        reset   = 1'b1;
        cpu_rd  = '0;
        cpu_we  = '0;
        irq_ack = '0;
        for (int d = 0; d < 2; d++) begin
            cpu_addr[d]  = '0;
            cpu_wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            check("rst cpu_ce", cpu_ce[d], 0);
            check("rst cpu_wait", cpu_wait[d], 0);
            check("rst mem_we", mem_we[d], 0);
            check("rst irq", irq[d], 0);
            check("rst cpu_rdata", cpu_rdata[d], 0);
            check("rst mem_addr", mem_addr[d], 0);
            check("rst mem_wdata", mem_wdata[d], 0);
        end

        // Clock n is the n-th rising edge after release; cpu_ce is sampled before it.
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check($sformatf("divider clk%0d cpu_ce", n), cpu_ce[0], (n % 4 == 0) ? 1 : 0);
            check($sformatf("quiet clk%0d", n), {irq[0], cpu_wait[0], mem_we[0]}, 0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                xact(d, vecs[i], $sformatf("dut%0d vec%0d", d, i));
            end
        end

        // Reset while a write on the wait-state instance sits in WAIT.
        @(negedge clk);
        wait_ce(1);
        cpu_we[1]    = 1'b1;
        cpu_addr[1]  = 16'h0020;
        cpu_wdata[1] = 8'hC3;
        @(posedge clk);
        #1;
        cpu_we[1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid-write cpu_wait", cpu_wait[1], 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort cpu_wait", cpu_wait[1], 0);
        check("abort mem_we", mem_we[1], 0);
        reset = 1'b0;
        check("abort cpu_rdata", cpu_rdata[1], 0);
        xact(1, vecs[1], "post-reset read");

        // Interrupt sequence: fresh reset so the period counter starts at 0.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_irq = '0;
        ack_on  = '0;
        exp_irq[10] = 1'b1; exp_irq[11] = 1'b1; exp_irq[12] = 1'b1;
        exp_irq[20] = 1'b1; exp_irq[21] = 1'b1; exp_irq[30] = 1'b1;
        ack_on[22]  = 1'b1; ack_on[25]  = 1'b1; ack_on[30]  = 1'b1; ack_on[31] = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            wait_ce(0);
            irq_ack[0] = ack_on[n];
            @(posedge clk);
            #1;
            irq_ack[0] = 1'b0;
            check($sformatf("irq after ce%0d", n), irq[0], exp_irq[n]);
        end
`ifdef IRQ_MISS_CNT_EN
        check("irq_miss", irq_miss[0], 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
Parametrised CPU-side system controller that replaces the ad-hoc divider, memory and interrupt logic around the z80 core.
- Generates a CPU clock-enable pulse from the single system clock.
- Sequences read/write accesses to a synchronous 1-cycle-latency RAM, with configurable wait states and a wait handshake back to the CPU.
- Produces a periodic maskable interrupt request (frame-style) held until acknowledged or timed out.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
CLK_DIV, 4, system clocks per CPU enable pulse (>=2)
WAIT_STATES, 0, extra system clocks inserted per memory access (0..15)
INT_PERIOD, 20000, CPU enables between interrupt requests (>=2)
INT_HOLD, 32, CPU enables irq stays high without acknowledge (>=1, <INT_PERIOD)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_ce  out  1  one-clk pulse, CPU advances one T-state
cpu_addr  in  ADDR_W  CPU bus address
cpu_wdata  in  DATA_W  CPU write data
cpu_rd  in  1  CPU read request, sampled on cpu_ce
cpu_we  in  1  CPU write request, sampled on cpu_ce
cpu_rdata  out  DATA_W  registered read data to CPU
cpu_wait  out  1  access in progress; CPU must not advance its bus cycle
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe, one clk
mem_rdata  in  DATA_W  RAM read data, valid 1 clk after mem_addr
irq  out  1  interrupt request to CPU
irq_ack  in  1  interrupt acknowledge from CPU, sampled on cpu_ce

Behaviour:
- Reset:
  - Divider=0, FSM=IDLE, irq counters=0.
  - All outputs 0: cpu_ce, cpu_wait, mem_we, irq, cpu_rdata, mem_addr, mem_wdata.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps; cpu_ce=1 exactly when count==CLK_DIV-1.
  - First cpu_ce occurs CLK_DIV clks after reset release.
  - Divider runs regardless of cpu_wait.
- Bus FSM states: IDLE, ISSUE, WAIT, DATA.
  - IDLE: on cpu_ce with cpu_rd|cpu_we, latch address/data/direction into mem_addr/mem_wdata, go ISSUE, cpu_wait<=1.
  - cpu_rd and cpu_we both set: treated as write.
  - ISSUE: write: mem_we=1 for this clk only. Read: RAM addressed. Then WAIT if WAIT_STATES>0, else DATA.
  - WAIT: counts WAIT_STATES clks, then DATA.
  - DATA: read: cpu_rdata<=mem_rdata. Clear cpu_wait. Go IDLE.
  - Access latency, capture clk to cpu_wait low: 2+WAIT_STATES clks.
  - Requests are ignored while FSM is not IDLE. Requests are ignored on clks without cpu_ce.
  - cpu_rdata holds its last value until the next read completes.
  - mem_addr holds its last value between accesses.
- Interrupt:
  - Period counter increments on each cpu_ce and wraps at INT_PERIOD-1.
  - On wrap: irq<=1, hold counter=0.
  - While irq=1, each cpu_ce increments hold counter. irq<=0 on cpu_ce with irq_ack=1, or when hold counter reaches INT_HOLD, whichever comes first.
  - Wrap and ack on the same cpu_ce: wrap wins. irq stays 1 and hold counter restarts.
  - irq_ack while irq=0: ignored.
- Reset mid-access: FSM to IDLE next clk. mem_we and cpu_wait drop immediately. No partial write is completed.

Optional Feature:
IRQ_MISS_CNT_EN
- Defined:
  - Adds output irq_miss [7:0], reset 0.
  - Increments, saturating at 255, each time irq drops through INT_HOLD expiry rather than irq_ack.
  - Also increments when a wrap occurs while irq is still high.
- Undefined: port absent, no counter logic.

Test Plan:
1. Reset release, CLK_DIV=4 -> cpu_ce pulses at clks 4, 8, 12; irq, cpu_wait, mem_we stay 0.
2. Write, WAIT_STATES=0: cpu_we=1, addr=16'h1234, data=8'hA5 at a cpu_ce -> next clk mem_we=1 for exactly 1 clk with mem_addr=16'h1234, mem_wdata=8'hA5; cpu_wait high 2 clks.
3. Read, WAIT_STATES=3: RAM[16'h0040]=8'h3C, cpu_rd at cpu_ce -> cpu_wait high 5 clks, then cpu_rdata=8'h3C.
4. Simultaneous rd+we at addr 16'h0010, data 8'h77 -> write performed (mem_we pulse); cpu_rdata unchanged.
5. INT_PERIOD=10, INT_HOLD=3, no ack -> irq rises on 10th cpu_ce, falls after 3 further cpu_ce. With ack on 2nd cpu_ce of irq-high -> irq falls on that cpu_ce. With IRQ_MISS_CNT_EN, irq_miss=1 after the unacked case only.
6. Reset asserted in WAIT state of a write -> next clk cpu_wait=0, mem_we=0, FSM IDLE; a fresh read after reset returns correct data.
